// File: rtl/nand_calib_pkg.sv
// -----------------------------------------------------------------------------
// nand_calib_pkg
// Shared definitions for the NAND DQS read-capture calibration sequencer:
// FSM state encoding, tap-width helper, default training patterns and the
// minimum low time between IODELAY tap-change pulses.
// No ports (package).
// -----------------------------------------------------------------------------
package nand_calib_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_REWIND,
      ST_SETTLE,
      ST_SAMPLE,
      ST_EVAL,
      ST_STEP,
      ST_CENTER,
      ST_DONE,
      ST_FAIL
   } cal_state_e;

   localparam logic [7:0] DEF_PATTERN_RISE = 8'hA5;
   localparam logic [7:0] DEF_PATTERN_FALL = 8'h5A;

   // Low cycles guaranteed between two consecutive dlyce_dqs pulses.
   localparam int PULSE_GAP = 1;

   // Bits needed to hold taps 0..max_tap.
   function automatic int tap_w(input int max_tap);
      return (max_tap < 1) ? 1 : $clog2(max_tap + 1);
   endfunction

endpackage

// File: rtl/nand_calib_dly_stepper.sv
// -----------------------------------------------------------------------------
// nand_calib_dly_stepper
// Owns the DQS IODELAY tap record and the PHY tap-change pins. A level request
// (inc_req/dec_req) is turned into a single-cycle dlyce_dqs pulse, spaced by at
// least PULSE_GAP low cycles, and never moves the tap past 0 or MAX_TAP.
// tap_cur reflects a pulse in the cycle after it; ack is high in that cycle.
// Ports:
//   clk0, rst0    clock, synchronous active-high reset
//   inc_req       request one increment pulse (level)
//   dec_req       request one decrement pulse (level)
//   dlyce_dqs     tap-change enable pulse to PHY
//   dlyinc_dqs    direction qualifier for dlyce_dqs (1 = increment)
//   ack           tap_cur has just absorbed a pulse
//   tap_cur       current tap record
// -----------------------------------------------------------------------------
module nand_calib_dly_stepper
   import nand_calib_pkg::*;
#(
   parameter int MAX_TAP = 63,
   parameter int TAP_W   = tap_w(MAX_TAP)
) (
   input  logic             clk0,
   input  logic             rst0,
   input  logic             inc_req,
   input  logic             dec_req,
   output logic             dlyce_dqs,
   output logic             dlyinc_dqs,
   output logic             ack,
   output logic [TAP_W-1:0] tap_cur
);

   localparam int GAP_W = (PULSE_GAP < 1) ? 1 : $clog2(PULSE_GAP + 1);
   localparam logic [TAP_W-1:0] TAP_MAX = TAP_W'(MAX_TAP);

   logic             pulse_q, pulse_d;
   logic             dir_q, dir_d;
   logic             ack_q, ack_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic [TAP_W-1:0] tap_q, tap_d;
   logic             can_inc, can_dec;

   assign can_inc = (tap_q != TAP_MAX);
   assign can_dec = (tap_q != '0);

   always_comb begin
      // NOTE: every variable gets a default first, so no path leaves a value
      // unassigned and no latch is inferred.
      pulse_d = 1'b0;
      dir_d   = dir_q;
      gap_d   = gap_q;
      tap_d   = tap_q;
      ack_d   = pulse_q;

      if (gap_q != '0) begin
         gap_d = gap_q - GAP_W'(1);
      end

      if (pulse_q) begin
         tap_d = dir_q ? tap_q + TAP_W'(1) : tap_q - TAP_W'(1);
      end else if (gap_q == '0) begin
         // tap_q is up to date here, so the no-wrap test sees the real tap.
         if (inc_req && can_inc) begin
            pulse_d = 1'b1;
            dir_d   = 1'b1;
            gap_d   = GAP_W'(PULSE_GAP);
         end else if (dec_req && can_dec) begin
            pulse_d = 1'b1;
            dir_d   = 1'b0;
            gap_d   = GAP_W'(PULSE_GAP);
         end
      end
   end

   always_ff @(posedge clk0) begin
      // NOTE: state is updated with non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (rst0) begin
         pulse_q <= 1'b0;
         dir_q   <= 1'b0;
         ack_q   <= 1'b0;
         gap_q   <= '0;
         tap_q   <= '0;
      end else begin
         pulse_q <= pulse_d;
         dir_q   <= dir_d;
         ack_q   <= ack_d;
         gap_q   <= gap_d;
         tap_q   <= tap_d;
      end
   end

   assign dlyce_dqs  = pulse_q;
   assign dlyinc_dqs = dir_q;
   assign ack        = ack_q;
   assign tap_cur    = tap_q;

endmodule

// File: rtl/nand_dqs_calib_ctrl.sv
// -----------------------------------------------------------------------------
// nand_dqs_calib_ctrl
// Read-capture calibration sequencer for the NAND PHY DQS IODELAY. Rewinds to
// tap 0, then at each tap waits SETTLE_CYC cycles, checks SAMPLE_CNT valid
// training reads against PATTERN_RISE/PATTERN_FALL, tracks the first
// contiguous passing window and finally parks DQS at the window centre.
// Optional build macro: NAND_CALIB_DEBUG_EN adds output pass_map.
// Ports:
//   clk0, rst0            clock, synchronous active-high reset
//   cal_start             one-cycle start request (ignored while busy)
//   rd_valid              rd_data_* carry training data this cycle
//   rd_data_rise/_fall    captured rise/fall data words
//   dlyce_dqs/dlyinc_dqs  IODELAY tap-change pulse and direction
//   cal_busy              calibration running
//   cal_done / cal_fail   result flags, held until next accepted start
//   tap_cur               current DQS tap record
//   win_first / win_last  passing window bounds of the last run
//   pass_map              (debug build only) per-tap pass bits
// -----------------------------------------------------------------------------
module nand_dqs_calib_ctrl
   import nand_calib_pkg::*;
#(
   parameter int                  DQ_WIDTH     = 8,
   parameter int                  MAX_TAP      = 63,
   parameter int                  SETTLE_CYC   = 8,
   parameter int                  SAMPLE_CNT   = 16,
   parameter logic [DQ_WIDTH-1:0] PATTERN_RISE = DQ_WIDTH'(DEF_PATTERN_RISE),
   parameter logic [DQ_WIDTH-1:0] PATTERN_FALL = DQ_WIDTH'(DEF_PATTERN_FALL),
   localparam int                 TAP_W        = tap_w(MAX_TAP)
) (
   input  logic                clk0,
   input  logic                rst0,
   input  logic                cal_start,
   input  logic                rd_valid,
   input  logic [DQ_WIDTH-1:0] rd_data_rise,
   input  logic [DQ_WIDTH-1:0] rd_data_fall,
   output logic                dlyce_dqs,
   output logic                dlyinc_dqs,
   output logic                cal_busy,
   output logic                cal_done,
   output logic                cal_fail,
   output logic [TAP_W-1:0]    tap_cur,
   output logic [TAP_W-1:0]    win_first,
   output logic [TAP_W-1:0]    win_last
`ifdef NAND_CALIB_DEBUG_EN
   ,
   output logic [MAX_TAP:0]    pass_map
`endif
);

   localparam int SETTLE_W = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC);
   localparam int SAMPLE_W = (SAMPLE_CNT < 2) ? 1 : $clog2(SAMPLE_CNT);
   localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYC - 1);
   localparam logic [SAMPLE_W-1:0] SAMPLE_LAST = SAMPLE_W'(SAMPLE_CNT - 1);
   localparam logic [TAP_W-1:0]    TAP_MAX     = TAP_W'(MAX_TAP);

   cal_state_e          state_q, state_d;
   logic [SETTLE_W-1:0] settle_q, settle_d;
   logic [SAMPLE_W-1:0] sample_q, sample_d;
   logic                tap_fail_q, tap_fail_d;
   logic                win_open_q, win_open_d;
   logic [TAP_W-1:0]    win_first_q, win_first_d;
   logic [TAP_W-1:0]    win_last_q, win_last_d;
`ifdef NAND_CALIB_DEBUG_EN
   logic [MAX_TAP:0]    pass_map_q, pass_map_d;
`endif

   logic             inc_req, dec_req, step_ack;
   logic             word_bad;
   logic [TAP_W:0]   center_sum;
   logic [TAP_W-1:0] center_tap;

   nand_calib_dly_stepper #(
      .MAX_TAP (MAX_TAP),
      .TAP_W   (TAP_W)
   ) u_stepper (
      .clk0       (clk0),
      .rst0       (rst0),
      .inc_req    (inc_req),
      .dec_req    (dec_req),
      .dlyce_dqs  (dlyce_dqs),
      .dlyinc_dqs (dlyinc_dqs),
      .ack        (step_ack),
      .tap_cur    (tap_cur)
   );

   assign word_bad = (rd_data_rise != PATTERN_RISE) || (rd_data_fall != PATTERN_FALL);

   // One extra bit so first+last cannot overflow before halving.
   assign center_sum = {1'b0, win_first_q} + {1'b0, win_last_q};
   assign center_tap = center_sum[TAP_W:1];

   // Tap moves in REWIND/CENTER are level requests: while a pulse is in flight
   // tap_cur is still the pre-pulse value (never the target), and the stepper
   // ignores the request until tap_cur has caught up.
   always_comb begin
      state_d     = state_q;
      settle_d    = settle_q;
      sample_d    = sample_q;
      tap_fail_d  = tap_fail_q;
      win_open_d  = win_open_q;
      win_first_d = win_first_q;
      win_last_d  = win_last_q;
`ifdef NAND_CALIB_DEBUG_EN
      pass_map_d  = pass_map_q;
`endif
      inc_req     = 1'b0;
      dec_req     = 1'b0;

      unique case (state_q)
         ST_IDLE, ST_DONE, ST_FAIL: begin
            if (cal_start) begin
               state_d     = ST_REWIND;
               win_open_d  = 1'b0;
               win_first_d = '0;
               win_last_d  = '0;
`ifdef NAND_CALIB_DEBUG_EN
               pass_map_d  = '0;
`endif
            end
         end
         ST_REWIND: begin
            if (tap_cur == '0) begin
               state_d    = ST_SETTLE;
               settle_d   = '0;
               tap_fail_d = 1'b0;
            end else begin
               dec_req = 1'b1;
            end
         end
         ST_SETTLE: begin
            if (settle_q == SETTLE_LAST) begin
               state_d  = ST_SAMPLE;
               sample_d = '0;
            end else begin
               settle_d = settle_q + SETTLE_W'(1);
            end
         end
         ST_SAMPLE: begin
            if (rd_valid) begin
               if (word_bad) tap_fail_d = 1'b1;
               if (sample_q == SAMPLE_LAST) state_d = ST_EVAL;
               else                         sample_d = sample_q + SAMPLE_W'(1);
            end
         end
         ST_EVAL: begin
            if (!tap_fail_q) begin
               if (!win_open_q) win_first_d = tap_cur;
               win_last_d = tap_cur;
               win_open_d = 1'b1;
`ifdef NAND_CALIB_DEBUG_EN
               pass_map_d[tap_cur] = 1'b1;
`endif
            end
            if (tap_fail_q && win_open_q) state_d = ST_CENTER;
            else if (tap_cur == TAP_MAX)  state_d = ST_CENTER;
            else                          state_d = ST_STEP;
         end
         ST_STEP: begin
            // Drop the request in the ack cycle so exactly one pulse is issued.
            inc_req = !step_ack;
            if (step_ack) begin
               state_d    = ST_SETTLE;
               settle_d   = '0;
               tap_fail_d = 1'b0;
            end
         end
         ST_CENTER: begin
            if (!win_open_q)                state_d = ST_FAIL;
            else if (tap_cur == center_tap) state_d = ST_DONE;
            else                            dec_req = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk0) begin
      if (rst0) begin
         state_q     <= ST_IDLE;
         settle_q    <= '0;
         sample_q    <= '0;
         tap_fail_q  <= 1'b0;
         win_open_q  <= 1'b0;
         win_first_q <= '0;
         win_last_q  <= '0;
`ifdef NAND_CALIB_DEBUG_EN
         pass_map_q  <= '0;
`endif
      end else begin
         state_q     <= state_d;
         settle_q    <= settle_d;
         sample_q    <= sample_d;
         tap_fail_q  <= tap_fail_d;
         win_open_q  <= win_open_d;
         win_first_q <= win_first_d;
         win_last_q  <= win_last_d;
`ifdef NAND_CALIB_DEBUG_EN
         pass_map_q  <= pass_map_d;
`endif
      end
   end

   assign cal_busy  = !(state_q inside {ST_IDLE, ST_DONE, ST_FAIL});
   assign cal_done  = (state_q == ST_DONE);
   assign cal_fail  = (state_q == ST_FAIL);
   assign win_first = win_first_q;
   assign win_last  = win_last_q;
`ifdef NAND_CALIB_DEBUG_EN
   assign pass_map  = pass_map_q;
`endif

endmodule

// File: tb/tb_nand_dqs_calib_ctrl.sv
// -----------------------------------------------------------------------------
// tb_nand_dqs_calib_ctrl
// Directed bench for nand_dqs_calib_ctrl. A small PHY model tracks the real
// IODELAY tap from dlyce_dqs/dlyinc_dqs and returns the training pattern only
// inside the configured passing window; expected results are hand-computed.
// Optional build macro: NAND_CALIB_DEBUG_EN (also checks pass_map).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_nand_dqs_calib_ctrl;

   localparam int TAP_W  = 6;
   localparam int BUDGET = 20000;

   logic             clk0 = 1'b0;
   logic             rst0;
   logic             cal_start;
   logic             rd_valid;
   logic [7:0]       rd_data_rise, rd_data_fall;
   logic             dlyce_dqs, dlyinc_dqs, cal_busy, cal_done, cal_fail;
   logic [TAP_W-1:0] tap_cur, win_first, win_last;
`ifdef NAND_CALIB_DEBUG_EN
   logic [63:0]      pass_map;
`endif

   always #5 clk0 = ~clk0;

   nand_dqs_calib_ctrl dut (
      .clk0         (clk0),
      .rst0         (rst0),
      .cal_start    (cal_start),
      .rd_valid     (rd_valid),
      .rd_data_rise (rd_data_rise),
      .rd_data_fall (rd_data_fall),
      .dlyce_dqs    (dlyce_dqs),
      .dlyinc_dqs   (dlyinc_dqs),
      .cal_busy     (cal_busy),
      .cal_done     (cal_done),
      .cal_fail     (cal_fail),
      .tap_cur      (tap_cur),
      .win_first    (win_first),
      .win_last     (win_last)
`ifdef NAND_CALIB_DEBUG_EN
      ,
      .pass_map     (pass_map)
`endif
   );

   // ---------------- PHY / data model ----------------
   int   pass_lo = 20;
   int   pass_hi = 35;
   bit   sparse_valid = 1'b0;
   int   phy_tap = 0;
   int   inc_cnt = 0;
   int   dec_cnt = 0;
   int   gap_viol = 0;
   int   vphase = 0;
   logic prev_ce = 1'b0;

   always @(posedge clk0) begin
      vphase <= (vphase == 2) ? 0 : vphase + 1;
      if (rst0) begin
         phy_tap <= 0;
         prev_ce <= 1'b0;
      end else begin
         prev_ce <= dlyce_dqs;
         if (dlyce_dqs) begin
            if (prev_ce) gap_viol <= gap_viol + 1;
            if (dlyinc_dqs) begin
               phy_tap <= phy_tap + 1;
               inc_cnt <= inc_cnt + 1;
            end else begin
               phy_tap <= phy_tap - 1;
               dec_cnt <= dec_cnt + 1;
            end
         end
      end
   end

   // Failing taps corrupt the fall word on odd taps and the rise word on even.
   always_comb begin
      rd_valid = sparse_valid ? (vphase == 0) : 1'b1;
      if (phy_tap >= pass_lo && phy_tap <= pass_hi) begin
         rd_data_rise = 8'hA5;
         rd_data_fall = 8'h5A;
      end else if ((phy_tap % 2) == 1) begin
         rd_data_rise = 8'hA5;
         rd_data_fall = 8'h5B;
      end else begin
         rd_data_rise = 8'h25;
         rd_data_fall = 8'h5A;
      end
   end

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Start a run and wait (bounded) for done/fail. Optionally pulse a second
   // start mid-run, which must be ignored.
   task automatic run_cal(input bit extra_start);
      int n;
      @(negedge clk0); cal_start = 1'b1;
      @(negedge clk0); cal_start = 1'b0;
      check("busy_on_start", 64'(cal_busy), 64'd1);
      check("flags_cleared", 64'({cal_done, cal_fail}), 64'd0);
      n = 0;
      while (!(cal_done || cal_fail) && n < BUDGET) begin
         @(negedge clk0);
         n++;
         if (extra_start && n == 40) cal_start = 1'b1;
         if (extra_start && n == 41) cal_start = 1'b0;
         if (extra_start && n == 45) check("busy_ignores_start", 64'(cal_busy), 64'd1);
      end
      check("finish_in_budget", 64'(n < BUDGET), 64'd1);
   endtask

   task automatic check_result(input string tag, input bit done, input int first,
                               input int last, input int tap);
      check({tag, "_done"},  64'(cal_done), 64'(done));
      check({tag, "_fail"},  64'(cal_fail), 64'(!done));
      check({tag, "_busy"},  64'(cal_busy), 64'd0);
      check({tag, "_first"}, 64'(win_first), 64'(first));
      check({tag, "_last"},  64'(win_last), 64'(last));
      check({tag, "_tap"},   64'(tap_cur), 64'(tap));
      check({tag, "_phy"},   64'(phy_tap), 64'(tap));
   endtask

   task automatic check_idle_zero(input string tag);
      check({tag, "_outs"}, 64'({dlyce_dqs, dlyinc_dqs, cal_busy, cal_done, cal_fail}), 64'd0);
      check({tag, "_tap"},  64'(tap_cur), 64'd0);
      check({tag, "_win"},  64'({win_first, win_last}), 64'd0);
`ifdef NAND_CALIB_DEBUG_EN
      check({tag, "_map"},  pass_map, 64'd0);
`endif
   endtask

   int inc0, dec0, n;

   initial begin
      rst0      = 1'b1;
      cal_start = 1'b0;
      repeat (3) @(negedge clk0);
      rst0 = 1'b0;
      @(negedge clk0);
      check_idle_zero("reset");

      // Case 1: window 20..35. Steps 0->36 (first failing tap), then 36->27.
      inc0 = inc_cnt; dec0 = dec_cnt;
      run_cal(1'b0);
      check_result("win20_35", 1'b1, 20, 35, 27);
      check("win20_35_incs", 64'(inc_cnt - inc0), 64'd36);
      check("win20_35_decs", 64'(dec_cnt - dec0), 64'd9);
`ifdef NAND_CALIB_DEBUG_EN
      check("win20_35_map", pass_map, 64'h0000_000F_FFF0_0000);
`endif
      repeat (5) @(negedge clk0);
      check("done_held", 64'({cal_done, cal_busy}), 64'b10);

      // Case 2: no passing tap. Rewind 27, step to 63, fail.
      pass_lo = 100; pass_hi = -1;
      inc0 = inc_cnt; dec0 = dec_cnt;
      run_cal(1'b0);
      check_result("nopass", 1'b0, 0, 0, 63);
      check("nopass_incs", 64'(inc_cnt - inc0), 64'd63);
      check("nopass_decs", 64'(dec_cnt - dec0), 64'd27);

      // Case 3: window 50..63, open at MAX_TAP. Rewind 63, centre 63->56.
      pass_lo = 50; pass_hi = 63;
      inc0 = inc_cnt; dec0 = dec_cnt;
      run_cal(1'b0);
      check_result("win50_63", 1'b1, 50, 63, 56);
      check("win50_63_incs", 64'(inc_cnt - inc0), 64'd63);
      check("win50_63_decs", 64'(dec_cnt - dec0), 64'd70);

      // Case 4: repeat from tap 56: 56 rewind pulses + 7 centring pulses.
      inc0 = inc_cnt; dec0 = dec_cnt;
      run_cal(1'b0);
      check_result("rerun", 1'b1, 50, 63, 56);
      check("rerun_decs", 64'(dec_cnt - dec0), 64'd63);
      check("pulse_spacing", 64'(gap_viol), 64'd0);

      // Case 5: rd_valid 1-in-3 and a stray start while busy.
      sparse_valid = 1'b1;
      inc0 = inc_cnt; dec0 = dec_cnt;
      run_cal(1'b1);
      check_result("sparse", 1'b1, 50, 63, 56);
      check("sparse_incs", 64'(inc_cnt - inc0), 64'd63);
      check("sparse_decs", 64'(dec_cnt - dec0), 64'd63);
      sparse_valid = 1'b0;

      // Case 6: reset while sampling at tap 10, then a clean run from 0.
      pass_lo = 20; pass_hi = 35;
      @(negedge clk0); cal_start = 1'b1;
      @(negedge clk0); cal_start = 1'b0;
      n = 0;
      while (tap_cur != '0 && n < BUDGET) begin @(negedge clk0); n++; end
      while (tap_cur != TAP_W'(10) && n < BUDGET) begin @(negedge clk0); n++; end
      check("reach_tap10", 64'(n < BUDGET), 64'd1);
      // 1 step-ack cycle + 8 settle cycles precede SAMPLE; 12 lands inside it.
      repeat (12) @(negedge clk0);
      check("busy_before_rst", 64'(cal_busy), 64'd1);
      rst0 = 1'b1;
      @(negedge clk0);
      check_idle_zero("midrst");
      rst0 = 1'b0;
      inc0 = inc_cnt; dec0 = dec_cnt;
      run_cal(1'b0);
      check_result("after_rst", 1'b1, 20, 35, 27);
      check("after_rst_incs", 64'(inc_cnt - inc0), 64'd36);
      check("after_rst_decs", 64'(dec_cnt - dec0), 64'd9);
`ifdef NAND_CALIB_DEBUG_EN
      check("after_rst_map", pass_map, 64'h0000_000F_FFF0_0000);
`endif
      check("final_spacing", 64'(gap_viol), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
